// File: rtl/bsg_manycore_ver_link_column_if.sv
// Bundle of cnt_p parallel valid/ready channels; used for edge (cnt_p=1)
// and per-node (cnt_p=num_nodes) link ports of the vertical column.
interface bsg_manycore_ver_link_column_if #(
    parameter int cnt_p   = 1,
    parameter int width_p = 64
);
    logic [cnt_p-1:0]              v;
    logic [cnt_p-1:0][width_p-1:0] data;
    logic [cnt_p-1:0]              ready;

    modport master (output v, output data, input  ready);
    modport slave  (input  v, input  data, output ready);
endinterface

// File: rtl/bsg_manycore_ver_link_column.sv
// Vertical link stitcher for a column of manycore nodes. Two independent
// streams (southbound, northbound) each cross num_nodes_p+1 hops; every hop
// is either a 2-entry retiming FIFO or a plain wire, chosen by a mask bit.

// One retimed hop: 2-entry FIFO with a registered source-side ready.
module bsg_manycore_ver_link_column_hop #(
    parameter int width_p = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_v,
    input  logic [width_p-1:0] in_data,
    output logic               in_ready,
    output logic               out_v,
    output logic [width_p-1:0] out_data,
    input  logic               out_ready
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    state_e                    state, state_next;
    logic [1:0][width_p-1:0]   mem;
    logic                      rd_ptr, wr_ptr;
    logic                      ready_r;
    logic                      enq, deq;

    assign enq      = in_v & ready_r;
    assign deq      = out_v & out_ready;
    assign in_ready = ready_r;
    assign out_v    = (state != EMPTY);
    assign out_data = mem[rd_ptr];

    // Occupancy transitions; enq while FULL cannot happen since ready is low.
    always_comb begin
        state_next = state;
        unique case (state)
            EMPTY:   if (enq) state_next = ONE;
            ONE: begin
                if (enq && !deq)      state_next = FULL;
                else if (deq && !enq) state_next = EMPTY;
            end
            FULL:    if (deq) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // State, pointers and registered ready; ready held low through reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= EMPTY;
            ready_r <= 1'b0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
        end else begin
            state   <= state_next;
            ready_r <= (state_next != FULL);
            if (enq) wr_ptr <= ~wr_ptr;
            if (deq) rd_ptr <= ~rd_ptr;
        end
    end

    // Payload storage needs no reset; it is only read while valid.
    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= in_data;
    end
endmodule

module bsg_manycore_ver_link_column #(
    parameter int                   num_nodes_p       = 2,
    parameter int                   width_p           = 64,
    parameter logic [num_nodes_p:0] sb_retime_mask_p  = '1,
    parameter logic [num_nodes_p:0] nb_retime_mask_p  = '1,
    parameter int                   stall_cnt_width_p = 16
) (
    input  logic                           mc_clk_i,
    input  logic                           mc_reset_i,
    bsg_manycore_ver_link_column_if.slave  sb_edge_in,
    bsg_manycore_ver_link_column_if.master sb_edge_out,
    bsg_manycore_ver_link_column_if.slave  nb_edge_in,
    bsg_manycore_ver_link_column_if.master nb_edge_out,
    bsg_manycore_ver_link_column_if.master sb_node_out,
    bsg_manycore_ver_link_column_if.slave  sb_node_in,
    bsg_manycore_ver_link_column_if.master nb_node_out,
    bsg_manycore_ver_link_column_if.slave  nb_node_in,
    input  logic                           stall_clear_i,
    output logic [stall_cnt_width_p-1:0]   sb_stall_cnt_o,
    output logic [stall_cnt_width_p-1:0]   nb_stall_cnt_o
);
    localparam int hops_lp = num_nodes_p + 1;

    if (num_nodes_p < 1) begin : g_bad_cfg
        $error("bsg_manycore_ver_link_column: num_nodes_p must be >= 1");
    end

    // Per-hop source (upstream) and sink (downstream) sides, indexed by hop.
    logic [hops_lp-1:0]              sb_src_v, sb_src_ready, sb_snk_v, sb_snk_ready;
    logic [hops_lp-1:0][width_p-1:0] sb_src_data, sb_snk_data;
    logic [hops_lp-1:0]              nb_src_v, nb_src_ready, nb_snk_v, nb_snk_ready;
    logic [hops_lp-1:0][width_p-1:0] nb_src_data, nb_snk_data;
    logic                            sb_stall, nb_stall;

    // Southbound: hop 0 fed by the north edge, hop h by node h-1's S port;
    // hop h delivers to node h's N port, the last hop to the south edge.
    assign sb_src_v          = {sb_node_in.v, sb_edge_in.v};
    assign sb_src_data       = {sb_node_in.data, sb_edge_in.data};
    assign sb_edge_in.ready  = sb_src_ready[0];
    assign sb_node_in.ready  = sb_src_ready[hops_lp-1:1];
    assign sb_node_out.v     = sb_snk_v[num_nodes_p-1:0];
    assign sb_node_out.data  = sb_snk_data[num_nodes_p-1:0];
    assign sb_edge_out.v     = sb_snk_v[num_nodes_p];
    assign sb_edge_out.data  = sb_snk_data[num_nodes_p];
    assign sb_snk_ready      = {sb_edge_out.ready, sb_node_out.ready};

    // Northbound: last hop fed by the south edge, hop h by node h's N port;
    // hop 0 delivers to the north edge, hop h to node h-1's S port.
    assign nb_src_v          = {nb_edge_in.v, nb_node_in.v};
    assign nb_src_data       = {nb_edge_in.data, nb_node_in.data};
    assign nb_node_in.ready  = nb_src_ready[num_nodes_p-1:0];
    assign nb_edge_in.ready  = nb_src_ready[num_nodes_p];
    assign nb_edge_out.v     = nb_snk_v[0];
    assign nb_edge_out.data  = nb_snk_data[0];
    assign nb_node_out.v     = nb_snk_v[hops_lp-1:1];
    assign nb_node_out.data  = nb_snk_data[hops_lp-1:1];
    assign nb_snk_ready      = {nb_node_out.ready, nb_edge_out.ready};

    for (genvar h = 0; h < hops_lp; h++) begin : g_hop
        if (sb_retime_mask_p[h]) begin : g_sb_reg
            bsg_manycore_ver_link_column_hop #(.width_p(width_p)) hop (
                .clk(mc_clk_i), .reset(mc_reset_i),
                .in_v(sb_src_v[h]), .in_data(sb_src_data[h]), .in_ready(sb_src_ready[h]),
                .out_v(sb_snk_v[h]), .out_data(sb_snk_data[h]), .out_ready(sb_snk_ready[h])
            );
        end else begin : g_sb_wire
            assign sb_snk_v[h]     = sb_src_v[h];
            assign sb_snk_data[h]  = sb_src_data[h];
            assign sb_src_ready[h] = sb_snk_ready[h];
        end

        if (nb_retime_mask_p[h]) begin : g_nb_reg
            bsg_manycore_ver_link_column_hop #(.width_p(width_p)) hop (
                .clk(mc_clk_i), .reset(mc_reset_i),
                .in_v(nb_src_v[h]), .in_data(nb_src_data[h]), .in_ready(nb_src_ready[h]),
                .out_v(nb_snk_v[h]), .out_data(nb_snk_data[h]), .out_ready(nb_snk_ready[h])
            );
        end else begin : g_nb_wire
            assign nb_snk_v[h]     = nb_src_v[h];
            assign nb_snk_data[h]  = nb_src_data[h];
            assign nb_src_ready[h] = nb_snk_ready[h];
        end
    end

    assign sb_stall = sb_snk_v[num_nodes_p] & ~sb_snk_ready[num_nodes_p];
    assign nb_stall = nb_snk_v[0] & ~nb_snk_ready[0];

    // Southbound edge stall counter: saturating, clear wins over increment.
    always_ff @(posedge mc_clk_i) begin
        if (mc_reset_i || stall_clear_i)
            sb_stall_cnt_o <= '0;
        else if (sb_stall && (sb_stall_cnt_o != '1))
            sb_stall_cnt_o <= sb_stall_cnt_o + stall_cnt_width_p'(1);
    end

    // Northbound edge stall counter: saturating, clear wins over increment.
    always_ff @(posedge mc_clk_i) begin
        if (mc_reset_i || stall_clear_i)
            nb_stall_cnt_o <= '0;
        else if (nb_stall && (nb_stall_cnt_o != '1))
            nb_stall_cnt_o <= nb_stall_cnt_o + stall_cnt_width_p'(1);
    end
endmodule
